// File: rtl/inv_cipher_round.sv
// One AES-128 decryption round (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns)
// with the inverse key schedule producing the previous round key alongside.
module inv_cipher_round #(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start,
  input  logic [127:0] block_in,
  input  logic [127:0] key_in,
  input  logic [31:0]  rcon_in,
  input  logic         final_in,
  output logic [127:0] block_out,
  output logic [127:0] key_out,
  output logic         block_complete
);

  typedef enum logic [2:0] {
    IDLE,
    INV_SHIFT,
    INV_SUB,
    ADD_KEY,
    INV_MIX,
    DONE
  } state_t;

  // A 4-bit counter wraps cleanly for every legal width; 16 bytes/cycle steps by 0 and exits at once.
  localparam logic [3:0] STEP = 4'(BYTES_PER_CYCLE);
  localparam logic [3:0] LAST = 4'(16 - BYTES_PER_CYCLE);

  state_t       state_q, state_d;
  logic [127:0] st;
  logic [127:0] key_r;
  logic [31:0]  rcon_r;
  logic         final_r;
  logic [3:0]   cnt;
  logic [127:0] prev_key_r;

  logic [127:0] st_shift;
  logic [127:0] st_sub;
  logic [127:0] st_mix;
  logic [127:0] key_prev;
  logic [3:0]   pos;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply, MSB first); maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int unsigned i = 0; i < 8; i++) begin
      r = gmul(r, r);
      if (e[7 - i]) r = gmul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = ginv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] x;
    x = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return ginv(x);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Row r rotated right by r: new (r,c) takes old (r,(c-r) mod 4).
  always_comb begin
    st_shift = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        st_shift[8*(15 - (4*c + r)) +: 8] = st[8*(15 - (4*((c + 4 - r) % 4) + r)) +: 8];
      end
    end
  end

  always_comb begin
    st_sub = st;
    pos    = '0;
    for (int unsigned j = 0; j < BYTES_PER_CYCLE; j++) begin
      pos = 4'hf - (cnt + 4'(j));
      st_sub[{pos, 3'b000} +: 8] = inv_sbox(st[{pos, 3'b000} +: 8]);
    end
  end

  always_comb begin
    st_mix = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      st_mix[32*(3 - c) +: 32] = inv_mix_col(st[32*(3 - c) +: 32]);
    end
  end

  always_comb begin
    logic [31:0] k0, k1, k2, k3, p3;
    key_prev = '0;
    {k0, k1, k2, k3} = key_r;
    p3 = k3 ^ k2;
    key_prev = {k0 ^ sub_word({p3[23:0], p3[31:24]}) ^ rcon_r, k1 ^ k0, k2 ^ k1, p3};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = INV_SHIFT;
      INV_SHIFT: state_d = INV_SUB;
      INV_SUB:   if (cnt == LAST) state_d = ADD_KEY;
      ADD_KEY:   state_d = final_r ? DONE : INV_MIX;
      INV_MIX:   state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      st             <= '0;
      key_r          <= '0;
      rcon_r         <= '0;
      final_r        <= 1'b0;
      cnt            <= '0;
      prev_key_r     <= '0;
      block_out      <= '0;
      key_out        <= '0;
      block_complete <= 1'b0;
    end else begin
      block_complete <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            st      <= block_in;
            key_r   <= key_in;
            rcon_r  <= rcon_in;
            final_r <= final_in;
          end
        end
        INV_SHIFT: begin
          st         <= st_shift;
          cnt        <= '0;
          prev_key_r <= key_prev;
        end
        INV_SUB: begin
          st  <= st_sub;
          cnt <= cnt + STEP;
        end
        ADD_KEY: begin
          st <= st ^ key_r;
          if (final_r) begin
            block_out      <= st ^ key_r;
            key_out        <= prev_key_r;
            block_complete <= 1'b1;
          end
        end
        INV_MIX: begin
          st             <= st_mix;
          block_out      <= st_mix;
          key_out        <= prev_key_r;
          block_complete <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_cipher_round.sv
// Directed bench for inv_cipher_round: one instance per BYTES_PER_CYCLE value,
// index 2 (4 bytes/cycle) carries the single-instance scenarios.
module tb_inv_cipher_round;

  localparam int M = 2;
  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [4:0]   start;
  logic [4:0]   fin;
  logic [4:0]   bc;
  logic [127:0] blk_in  [5];
  logic [127:0] key_in  [5];
  logic [31:0]  rcon_in [5];
  logic [127:0] blk_out [5];
  logic [127:0] key_out [5];

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] sb [17] = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
                          8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76, 8'hca};
  logic [7:0] rc [10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    inv_cipher_round #(.BYTES_PER_CYCLE(1 << g)) u_dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .start         (start[g]),
      .block_in      (blk_in[g]),
      .key_in        (key_in[g]),
      .rcon_in       (rcon_in[g]),
      .final_in      (fin[g]),
      .block_out     (blk_out[g]),
      .key_out       (key_out[g]),
      .block_complete(bc[g])
    );
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts one block on the 4-byte instance, returns latency and the outputs at the pulse.
  task automatic run_main(input logic [127:0] b, input logic [127:0] k, input logic [31:0] r,
                          input logic f, output int lat, output logic [127:0] o,
                          output logic [127:0] ko);
    blk_in[M] = b; key_in[M] = k; rcon_in[M] = r; fin[M] = f;
    start[M] = 1'b1;
    tick();
    start[M] = 1'b0;
    lat = 0;
    while (bc[M] !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    o  = blk_out[M];
    ko = key_out[M];
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    vectors++;
    if (blk_out[M] !== '0) begin
      miscompares++; $display("FAIL reset_block_out got %h want 0", blk_out[M]);
    end
    vectors++;
    if (key_out[M] !== '0) begin
      miscompares++; $display("FAIL reset_key_out got %h want 0", key_out[M]);
    end
    vectors++;
    if (bc !== 5'b0) begin
      miscompares++; $display("FAIL reset_complete got %b want 00000", bc);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_final;
    int lat;
    logic [127:0] o, ko;
    run_main('0, '0, 32'h01000000, 1'b1, lat, o, ko);
    vectors++;
    if (lat !== 6) begin
      miscompares++; $display("FAIL zero_latency got %0d want 6", lat);
    end
    vectors++;
    if (o !== {16{8'h52}}) begin
      miscompares++; $display("FAIL zero_block got %h want %h", o, {16{8'h52}});
    end
    vectors++;
    if (ko !== 128'h62636363_00000000_00000000_00000000) begin
      miscompares++; $display("FAIL zero_key got %h want 62636363000000000000000000000000", ko);
    end
  endtask

  task automatic test_inv_mix;
    int lat;
    blk_in[M] = '0; key_in[M] = 128'hdc1ff3ee_52525252_52525252_52525252;
    rcon_in[M] = 32'h01000000; fin[M] = 1'b0;
    start[M] = 1'b1;
    tick();
    start[M] = 1'b0;
    tick();
    tick();
    vectors++;
    if (blk_out[M] !== {16{8'h52}}) begin
      miscompares++; $display("FAIL hold_block got %h want %h", blk_out[M], {16{8'h52}});
    end
    lat = 2;
    while (bc[M] !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    vectors++;
    if (lat !== 7) begin
      miscompares++; $display("FAIL mix_latency got %0d want 7", lat);
    end
    vectors++;
    if (blk_out[M] !== 128'hdb135345_00000000_00000000_00000000) begin
      miscompares++; $display("FAIL mix_block got %h want db135345000000000000000000000000", blk_out[M]);
    end
    tick();
  endtask

  task automatic test_key_schedule;
    int lat;
    logic [127:0] o, ko;
    run_main('0, K10, 32'h36000000, 1'b1, lat, o, ko);
    vectors++;
    if (ko !== K9) begin
      miscompares++; $display("FAIL keysched_key got %h want %h", ko, K9);
    end
    vectors++;
    if (o !== ({16{8'h52}} ^ K10)) begin
      miscompares++; $display("FAIL keysched_block got %h want %h", o, {16{8'h52}} ^ K10);
    end
  endtask

  task automatic test_back_to_back;
    int np;
    int edge_at [3];
    logic [127:0] val_at [3];
    logic prev;
    int dbl;
    int exp_edge [3];
    np = 0; dbl = 0; prev = 1'b0;
    exp_edge[0] = 6; exp_edge[1] = 14; exp_edge[2] = 22;
    for (int k = 0; k < 3; k++) begin
      edge_at[k] = -1; val_at[k] = 'x;
    end
    key_in[M] = '0; rcon_in[M] = 32'h01000000; fin[M] = 1'b1;
    for (int t = 0; t < 29; t++) begin
      if (t < 17) begin
        blk_in[M] = {16{sb[t]}};
        start[M] = 1'b1;
      end else begin
        start[M] = 1'b0;
      end
      tick();
      if (bc[M] === 1'b1) begin
        if (prev) dbl++;
        if (np < 3) begin
          edge_at[np] = t; val_at[np] = blk_out[M];
        end
        np++;
      end
      prev = (bc[M] === 1'b1);
    end
    vectors++;
    if (np !== 3) begin
      miscompares++; $display("FAIL b2b_pulse_count got %0d want 3", np);
    end
    vectors++;
    if (dbl !== 0) begin
      miscompares++; $display("FAIL b2b_double_pulse got %0d want 0", dbl);
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (edge_at[k] !== exp_edge[k] || val_at[k] !== {16{8'(exp_edge[k] - 6)}}) begin
        miscompares++;
        $display("FAIL b2b_block%0d got edge %0d %h want edge %0d %h", k, edge_at[k], val_at[k],
                 exp_edge[k], {16{8'(exp_edge[k] - 6)}});
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int np;
    logic [127:0] o, ko;
    blk_in[M] = '0; key_in[M] = '0; rcon_in[M] = 32'h01000000; fin[M] = 1'b1;
    start[M] = 1'b1;
    tick();
    start[M] = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (blk_out[M] !== '0 || key_out[M] !== '0) begin
      miscompares++; $display("FAIL midreset_outputs got %h %h want 0 0", blk_out[M], key_out[M]);
    end
    tick();
    rst = 1'b0;
    np = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (bc[M] === 1'b1) np++;
    end
    vectors++;
    if (np !== 0) begin
      miscompares++; $display("FAIL midreset_pulses got %0d want 0", np);
    end
    run_main('0, '0, 32'h01000000, 1'b1, lat, o, ko);
    vectors++;
    if (o !== {16{8'h52}} || ko !== 128'h62636363_00000000_00000000_00000000 || lat !== 6) begin
      miscompares++; $display("FAIL midreset_rerun got %h %h lat %0d want %h 62636363000000000000000000000000 lat 6",
                              o, ko, lat, {16{8'h52}});
    end
  endtask

  task automatic test_chain;
    logic [127:0] st [5];
    logic [127:0] ky [5];
    logic [4:0] seen;
    int n;
    for (int g = 0; g < 5; g++) begin
      st[g] = CT ^ K10;
      ky[g] = K9;
    end
    for (int j = 9; j >= 0; j--) begin
      for (int g = 0; g < 5; g++) begin
        blk_in[g] = st[g]; key_in[g] = ky[g];
        rcon_in[g] = {rc[j], 24'h0}; fin[g] = (j == 0);
      end
      start = 5'h1f;
      tick();
      start = 5'h00;
      seen = '0;
      n = 0;
      while (seen !== 5'h1f && n < 40) begin
        tick();
        n++;
        for (int g = 0; g < 5; g++) begin
          if (bc[g] === 1'b1 && !seen[g]) begin
            seen[g] = 1'b1;
            st[g] = blk_out[g];
            ky[g] = key_out[g];
          end
        end
      end
      vectors++;
      if (seen !== 5'h1f) begin
        miscompares++; $display("FAIL chain_round%0d_complete got %b want 11111", j, seen);
      end
      tick();
    end
    for (int g = 0; g < 5; g++) begin
      vectors++;
      if (st[g] !== PT) begin
        miscompares++; $display("FAIL chain_bpc%0d got %h want %h", 1 << g, st[g], PT);
      end
    end
  endtask

  initial begin
    start = '0;
    fin = '0;
    for (int g = 0; g < 5; g++) begin
      blk_in[g] = '0; key_in[g] = '0; rcon_in[g] = '0;
    end
    test_reset();
    test_zero_final();
    test_inv_mix();
    test_key_schedule();
    test_back_to_back();
    test_reset_mid();
    test_chain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
